// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
// -----------------
// Operand sequencer and result collector for one external mac_unit column.
// Takes a start command carrying a term count. Streams operand pairs from a
// valid/ready source into the MAC. Closes the accumulator loop
// (acc_out -> acc_in) and presents the finished dot product on a valid/ready
// result port.
//
// Parameters
//   DATA_WIDTH : operand width; accumulator/result width is 2*DATA_WIDTH
//   LEN_WIDTH  : width of the term count
//
// Ports
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   start, len         : command strobe and term count (accepted in IDLE only)
//   busy               : high whenever not IDLE
//   op_valid, op_ready : operand pair handshake (op_ready high only in RUN)
//   op_a, op_b         : signed operand pair
//   mac_a, mac_b       : MAC multiplier inputs
//   mac_acc_in         : MAC accumulator input
//   mac_acc_out        : MAC registered accumulator output (1-cycle latency)
//   res_valid, res_data, res_ready : result handshake and dot product
//   abort              : only with MAC_DOT_SEQ_ABORT_EN defined; drops an
//                        in-flight command from RUN or DRAIN without a result
//
// Configuration macro: MAC_DOT_SEQ_ABORT_EN (undefined by default).

module mac_dot_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic        [LEN_WIDTH-1:0]    len,
  output logic                           busy,
  input  logic                           op_valid,
  input  logic signed [DATA_WIDTH-1:0]   op_a,
  input  logic signed [DATA_WIDTH-1:0]   op_b,
  output logic                           op_ready,
  output logic signed [DATA_WIDTH-1:0]   mac_a,
  output logic signed [DATA_WIDTH-1:0]   mac_b,
  output logic signed [2*DATA_WIDTH-1:0] mac_acc_in,
  input  logic signed [2*DATA_WIDTH-1:0] mac_acc_out,
`ifdef MAC_DOT_SEQ_ABORT_EN
  input  logic                           abort,
`endif
  output logic                           res_valid,
  output logic signed [2*DATA_WIDTH-1:0] res_data,
  input  logic                           res_ready
);

  localparam int ACC_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                      state, state_nxt;
  logic        [LEN_WIDTH-1:0] cnt, cnt_nxt;
  logic                        first, first_nxt;
  logic signed [ACC_WIDTH-1:0] res_q, res_nxt;
  logic                        abort_act;
  logic                        accept;

  // abort only matters while a command is in flight
`ifdef MAC_DOT_SEQ_ABORT_EN
  assign abort_act = abort & ((state == S_RUN) | (state == S_DRAIN));
`else
  assign abort_act = 1'b0;
`endif

  // A term is taken only when it is not overruled by abort in the same cycle.
  assign accept = (state == S_RUN) & op_valid & ~abort_act;

  assign res_data = res_q;

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      first <= 1'b0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      first <= first_nxt;
      res_q <= res_nxt;
    end
  end

  // ---- next state and combinational drives ----
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    first_nxt  = first;
    res_nxt    = res_q;
    busy       = (state != S_IDLE);
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    mac_acc_in = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            cnt_nxt   = len;
            first_nxt = 1'b1;
            state_nxt = S_RUN;
          end else begin
            res_nxt   = '0;
            state_nxt = S_DONE;
          end
        end
      end

      S_RUN: begin
        op_ready = 1'b1;
        // The first term restarts the sum, so stale MAC contents never leak
        // into a new command. Zero operands during stalls keep the sum held.
        mac_acc_in = first ? '0 : mac_acc_out;
        if (accept) begin
          mac_a     = op_a;
          mac_b     = op_b;
          first_nxt = 1'b0;
          cnt_nxt   = cnt - 1'b1;
          if (cnt == LEN_WIDTH'(1)) begin
            state_nxt = S_DRAIN;
          end
        end
        if (abort_act) begin
          cnt_nxt   = '0;
          first_nxt = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      S_DRAIN: begin
        // The last product has just landed in the MAC register.
        mac_acc_in = mac_acc_out;
        if (abort_act) begin
          state_nxt = S_IDLE;
        end else begin
          res_nxt   = mac_acc_out;
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
module tb_mac_dot_sequencer;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int AW = 2 * DW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic        [LW-1:0] len;
  logic                 busy;
  logic                 op_valid;
  logic signed [DW-1:0] op_a, op_b;
  logic                 op_ready;
  logic signed [DW-1:0] mac_a, mac_b;
  logic signed [AW-1:0] mac_acc_in, mac_acc_out;
  logic                 res_valid;
  logic signed [AW-1:0] res_data;
  logic                 res_ready;
`ifdef MAC_DOT_SEQ_ABORT_EN
  logic                 abort;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic signed [DW-1:0] av[16];
  logic signed [DW-1:0] bv[16];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: external MAC with registered accumulator, sharing rst.
  always @(posedge clk or posedge rst) begin
    if (rst) mac_acc_out <= '0;
    else     mac_acc_out <= mac_acc_in + mac_a * mac_b;
  end

  mac_dot_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .op_valid    (op_valid),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_ready    (op_ready),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_acc_in  (mac_acc_in),
    .mac_acc_out (mac_acc_out),
`ifdef MAC_DOT_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ready   (res_ready)
  );

  // Reference: dot product of the first n pairs, wrapped to AW bits.
  function automatic logic signed [AW-1:0] ref_dot(input int n);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(av[i]) * longint'(bv[i]);
    return AW'(s);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int n);
    start = 1'b1;
    len   = LW'(n);
    #1;
    check("idle_busy", busy, 0);
    check("idle_op_ready", op_ready, 0);
    tick();
    start = 1'b0;
    len   = LW'($urandom);
  endtask

  task automatic feed(input int n, input int gap_lo, input int gap_hi);
    int g;
    logic signed [AW-1:0] held;
    for (int i = 0; i < n; i++) begin
      g    = (i == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo));
      held = mac_acc_out;
      for (int k = 0; k < g; k++) begin
        op_valid = 1'b0;
        op_a     = DW'($urandom);
        op_b     = DW'($urandom);
        #1;
        check("stall_mac_a", mac_a, 0);
        tick();
      end
      if (g > 0) check("stall_hold", mac_acc_out, held);
      op_valid = 1'b1;
      op_a     = av[i];
      op_b     = bv[i];
      #1;
      check("run_op_ready", op_ready, 1);
      check("run_mac_b", mac_b, bv[i]);
      tick();
    end
    op_valid = 1'b0;
  endtask

  task automatic collect(input logic signed [AW-1:0] exp, input int exp_lat, input int hold);
    int lat;
    lat      = 0;
    op_valid = 1'b0;
    while (!res_valid && lat < 8) begin
      tick();
      lat++;
    end
    check("res_latency", lat, exp_lat);
    check("res_data", res_data, exp);
    for (int k = 0; k < hold; k++) begin
      start    = 1'b1;
      len      = 8'd3;
      op_valid = 1'b1;
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, exp);
      check("hold_op_ready", op_ready, 0);
    end
    res_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd2;
    op_valid  = 1'b0;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    #1;
    check("done_busy_drop", busy, 0);
    check("done_valid_drop", res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
`ifdef MAC_DOT_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    #12;
    check("rst_busy", busy, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_mac_acc_in", mac_acc_in, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // basic sum
    av[0] = 2;  bv[0] = 3;
    av[1] = -4; bv[1] = 5;
    av[2] = 7;  bv[2] = -1;
    issue(3);
    feed(3, 0, 0);
    collect(-32'sd21, 1, 0);

    // zero length
    issue(0);
    collect('0, 0, 0);

    // operand stalls of two cycles
    issue(3);
    feed(3, 2, 2);
    collect(-32'sd21, 1, 0);

    // result backpressure with start pulses
    issue(3);
    feed(3, 0, 0);
    collect(-32'sd21, 1, 5);

    // wrap-around
    for (int i = 0; i < 3; i++) begin
      av[i] = -16'sd32768;
      bv[i] = -16'sd32768;
    end
    issue(3);
    feed(3, 0, 0);
    collect(32'hC000_0000, 1, 0);

    // reset mid-RUN after one of three terms
    av[0] = 9; bv[0] = 11;
    issue(3);
    feed(1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_op_ready", op_ready, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_mac_acc_in", mac_acc_in, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    av[0] = 5; bv[0] = 6;
    issue(1);
    feed(1, 0, 0);
    collect(32'sd30, 1, 0);

`ifdef MAC_DOT_SEQ_ABORT_EN
    // abort mid-RUN, same cycle as an offered operand
    av[0] = 9; bv[0] = 11;
    issue(3);
    feed(1, 0, 0);
    abort    = 1'b1;
    op_valid = 1'b1;
    op_a     = 16'sd100;
    op_b     = 16'sd100;
    tick();
    abort    = 1'b0;
    op_valid = 1'b0;
    check("abort_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_valid", res_valid, 0);
    end
    av[0] = 5; bv[0] = 6;
    issue(1);
    feed(1, 0, 0);
    collect(32'sd30, 1, 0);
`endif

    // randomized commands
    for (int t = 0; t < 24; t++) begin
      n = int'($urandom_range(8, 0));
      for (int i = 0; i < n; i++) begin
        av[i] = DW'($urandom);
        bv[i] = DW'($urandom);
      end
      issue(n);
      if (n > 0) feed(n, 0, 2);
      collect(ref_dot(n), (n > 0) ? 1 : 0, int'($urandom_range(2, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
